// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TIME_W = 2;

  localparam logic [TIME_W-1:0] TUSE_NONE = 2'b11;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_E  = 2'b01,
    FWD_M  = 2'b10,
    FWD_W  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [TIME_W-1:0] tnew;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
  } stage_t;

  function automatic logic [TIME_W-1:0] sat_dec(input logic [TIME_W-1:0] x);
    return (x == '0) ? '0 : x - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: captures the upstream record with Tnew counted down.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   bubble,
  input  stage_t din,
  output stage_t q
);

  stage_t nxt;

  always_comb begin
    nxt      = din;
    nxt.tnew = sat_dec(din.tnew);
  end

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall detection and forwarding-select generation from E/M/W shadows of in-flight instructions.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [1:0] tnew_d,
  input  logic [4:0] dst_d,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic [1:0] fwd_rt_m
);

  stage_t d_rec;
  stage_t e_q;
  stage_t m_q;
  stage_t w_q;

  assign d_rec = '{dst: dst_d, tnew: tnew_d, rs: rs_d, rt: rt_d};

  // Each stage applies one saturating decrement, so E sees sat_dec(tnew_d).
  hazard_stage_reg u_stage_e (
    .clk   (clk),
    .reset (reset),
    .bubble(stall),
    .din   (d_rec),
    .q     (e_q)
  );

  hazard_stage_reg u_stage_m (
    .clk   (clk),
    .reset (reset),
    .bubble(1'b0),
    .din   (e_q),
    .q     (m_q)
  );

  hazard_stage_reg u_stage_w (
    .clk   (clk),
    .reset (reset),
    .bubble(1'b0),
    .din   (m_q),
    .q     (w_q)
  );

  function automatic logic hazard(input logic [REG_W-1:0] r,
                                  input logic [TIME_W-1:0] tuse,
                                  input stage_t s);
    return (tuse != TUSE_NONE) && (r != '0) && (s.dst == r) && (s.tnew > tuse);
  endfunction

  function automatic logic fwd_ok(input logic [REG_W-1:0] r, input stage_t s);
    return (r != '0) && (s.dst == r) && (s.tnew == '0);
  endfunction

  always_comb begin
    stall = hazard(rs_d, tuse_rs_d, e_q) | hazard(rs_d, tuse_rs_d, m_q) |
            hazard(rt_d, tuse_rt_d, e_q) | hazard(rt_d, tuse_rt_d, m_q);
  end

  always_comb begin
    fwd_rs_d = FWD_RF;
    if (fwd_ok(rs_d, e_q))      fwd_rs_d = FWD_E;
    else if (fwd_ok(rs_d, m_q)) fwd_rs_d = FWD_M;
    else if (fwd_ok(rs_d, w_q)) fwd_rs_d = FWD_W;

    fwd_rt_d = FWD_RF;
    if (fwd_ok(rt_d, e_q))      fwd_rt_d = FWD_E;
    else if (fwd_ok(rt_d, m_q)) fwd_rt_d = FWD_M;
    else if (fwd_ok(rt_d, w_q)) fwd_rt_d = FWD_W;

    fwd_rs_e = FWD_RF;
    if (fwd_ok(e_q.rs, m_q))      fwd_rs_e = FWD_M;
    else if (fwd_ok(e_q.rs, w_q)) fwd_rs_e = FWD_W;

    fwd_rt_e = FWD_RF;
    if (fwd_ok(e_q.rt, m_q))      fwd_rt_e = FWD_M;
    else if (fwd_ok(e_q.rt, w_q)) fwd_rt_e = FWD_W;

    fwd_rt_m = FWD_RF;
    if (fwd_ok(m_q.rt, w_q)) fwd_rt_m = FWD_W;
  end

  // M.rs and W.rs/rt are carried for completeness but not consumed here.
  logic unused_fields;
  assign unused_fields = ^{m_q.rs, w_q.rs, w_q.rt};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl with hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .rs_d     (rs_d),
    .rt_d     (rt_d),
    .tuse_rs_d(tuse_rs_d),
    .tuse_rt_d(tuse_rt_d),
    .tnew_d   (tnew_d),
    .dst_d    (dst_d),
    .stall    (stall),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       chk;
    logic [4:0] rs, rt;
    logic [1:0] tus, tut, tn;
    logic [4:0] dst;
    logic       stall;
    logic [1:0] frsd, frtd, frse, frte, frtm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic chk,
                             input logic [4:0] rs, input logic [4:0] rt,
                             input logic [1:0] tus, input logic [1:0] tut,
                             input logic [1:0] tn, input logic [4:0] dst,
                             input logic st, input logic [1:0] frsd,
                             input logic [1:0] frtd, input logic [1:0] frse,
                             input logic [1:0] frte, input logic [1:0] frtm);
    vec_t r;
    r.rst = rst; r.chk = chk; r.rs = rs; r.rt = rt;
    r.tus = tus; r.tut = tut; r.tn = tn; r.dst = dst;
    r.stall = st; r.frsd = frsd; r.frtd = frtd;
    r.frse = frse; r.frte = frte; r.frtm = frtm;
    return r;
  endfunction

  function automatic vec_t nop(input logic [1:0] frse, input logic [1:0] frte,
                               input logic [1:0] frtm);
    return v(0, 1, 0, 0, 3, 3, 0, 0, 0, 0, 0, frse, frte, frtm);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int frsd,
                           input int frtd, input int frse, input int frte,
                           input int frtm);
    check({tag, " stall"},    int'(stall),    st);
    check({tag, " fwd_rs_d"}, int'(fwd_rs_d), frsd);
    check({tag, " fwd_rt_d"}, int'(fwd_rt_d), frtd);
    check({tag, " fwd_rs_e"}, int'(fwd_rs_e), frse);
    check({tag, " fwd_rt_e"}, int'(fwd_rt_e), frte);
    check({tag, " fwd_rt_m"}, int'(fwd_rt_m), frtm);
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tus, input logic [1:0] tut,
                       input logic [1:0] tn, input logic [4:0] dst);
    rs_d = rs; rt_d = rt; tuse_rs_d = tus; tuse_rt_d = tut;
    tnew_d = tn; dst_d = dst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stall_cycles;
    bit done;

    reset = 1'b1;
    set_d(0, 0, 3, 3, 0, 0);

    // reset with arbitrary D inputs, then release
    tbl.push_back(v(1, 0, 7, 7, 0, 0, 3, 7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 7, 7, 0, 0, 3, 7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 7, 7, 0, 0, 3, 7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    // addu $1 -> beq $1
    tbl.push_back(v(0, 1, 5, 6, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 3, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(nop(3, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    // lw $2 -> addu reading $2
    tbl.push_back(v(0, 1, 9, 0, 1, 3, 3, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 2, 10, 1, 1, 2, 11, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 2, 10, 1, 1, 2, 11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(3, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    // addu $3 -> sw rt=$3
    tbl.push_back(v(0, 1, 12, 13, 1, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 14, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 2, 0));
    tbl.push_back(nop(0, 0, 3));
    tbl.push_back(nop(0, 0, 0));
    // lw $0 -> beq $0
    tbl.push_back(v(0, 1, 15, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    // addu $4 -> ori $4 -> beq $4
    tbl.push_back(v(0, 1, 16, 17, 1, 1, 2, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 18, 0, 1, 3, 2, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 4, 0, 0, 3, 0, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 4, 0, 0, 3, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(nop(3, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    // E beats M on D selects, M beats W on E selects, W feeds M store data
    tbl.push_back(v(0, 1, 0, 0, 3, 3, 2, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 3, 3, 1, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 5, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(nop(2, 2, 0));
    tbl.push_back(nop(0, 0, 3));
    tbl.push_back(nop(0, 0, 0));

    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      set_d(tbl[i].rs, tbl[i].rt, tbl[i].tus, tbl[i].tut, tbl[i].tn, tbl[i].dst);
      @(negedge clk);
      if (tbl[i].chk)
        check_all($sformatf("row%0d", i), tbl[i].stall, tbl[i].frsd, tbl[i].frtd,
                  tbl[i].frse, tbl[i].frte, tbl[i].frtm);
      tick();
    end

    // reset asserted during a stall
    reset = 1'b0;
    set_d(0, 0, 3, 3, 0, 0);
    tick(); tick(); tick();
    set_d(16, 17, 1, 1, 2, 4); tick();
    set_d(18, 0, 1, 3, 2, 4);  tick();
    set_d(4, 0, 0, 3, 0, 0);
    @(negedge clk);
    check("rst_mid pre stall", int'(stall), 1);
    check("rst_mid pre fwd_rs_d", int'(fwd_rs_d), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_all("rst_mid post", 0, 0, 0, 0, 0, 0);
    tick();

    // lw -> dependent beq: two stall cycles, then forward from W
    set_d(0, 0, 3, 3, 0, 0);
    tick(); tick(); tick();
    set_d(0, 0, 3, 3, 3, 6); tick();
    set_d(6, 0, 0, 3, 0, 0);
    stall_cycles = 0;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1;
      else begin
        stall_cycles++;
        tick();
      end
    end
    check("lw_beq stall ended", int'(done), 1);
    check("lw_beq stall cycles", stall_cycles, 2);
    check("lw_beq fwd_rs_d", int'(fwd_rs_d), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule
